// File: rtl/cache_controller.sv
// Sequencing controller for the 64-line direct-mapped data cache: tag/valid/dirty
// store, hit/miss decode, write-back eviction and line fill over a req/ack memory port.
module cache_controller #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic              dc_read_cache,
  output logic              dc_write_cache,
  output logic              dc_fetch,
  output logic              dc_update,
  output logic [5:0]        dc_index,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_W = ADDR_W - 8;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_READ, WB_MEM, FILL, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic              refill;
  logic [63:0]       valid;
  logic [63:0]       dirty;
  logic [TAG_W-1:0]  tag_mem [64];
  logic [5:0]        idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              unused_addr_bits;

  assign idx              = req_addr[7:2];
  assign req_tag          = req_addr[ADDR_W-1:8];
  assign hit              = valid[idx] && (tag_mem[idx] == req_tag);
  assign unused_addr_bits = ^req_addr[1:0];

  assign cpu_busy = (state != IDLE);
  assign cpu_ack  = (state == RESP);
  assign dc_index = (state == IDLE) ? 6'd0 : idx;

  always_comb begin
    state_nxt      = state;
    dc_read_cache  = 1'b0;
    dc_write_cache = 1'b0;
    dc_fetch       = 1'b0;
    dc_update      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    case (state)
      IDLE: begin
        if (cpu_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          dc_read_cache  = !req_we;
          dc_write_cache = req_we;
          state_nxt      = RESP;
        end else if (valid[idx] && dirty[idx]) begin
          state_nxt = WB_READ;
        end else begin
          state_nxt = FILL;
        end
      end
      WB_READ: begin
        dc_update = 1'b1;
        state_nxt = WB_MEM;
      end
      WB_MEM: begin
        // Victim address comes from the resident tag, which cannot change until this ack.
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_mem[idx], idx, 2'b00};
        if (mem_ack) state_nxt = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, 2'b00};
        if (mem_ack) begin
          dc_fetch  = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_we     <= 1'b0;
      refill     <= 1'b0;
      valid      <= '0;
      dirty      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr <= cpu_addr;
            req_we   <= cpu_we;
            refill   <= 1'b0;
          end
        end
        LOOKUP: begin
          // The post-fill lookup always hits and belongs to an already-counted miss.
          if (!refill) begin
            if (hit) hit_count  <= hit_count + CNT_W'(1);
            else     miss_count <= miss_count + CNT_W'(1);
          end
          if (hit && req_we) dirty[idx] <= 1'b1;
        end
        WB_MEM: begin
          if (mem_ack) dirty[idx] <= 1'b0;
        end
        FILL: begin
          if (mem_ack) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            refill     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && (state == FILL) && mem_ack) tag_mem[idx] <= req_tag;
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vector table, hand-written reset corner case,
// and randomized traffic compared against a line-level cache model.
module tb_cache_controller;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic        cpu_busy;
  logic        cpu_ack;
  logic        dc_read_cache;
  logic        dc_write_cache;
  logic        dc_fetch;
  logic        dc_update;
  logic [5:0]  dc_index;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  cache_controller #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack),
    .dc_read_cache(dc_read_cache), .dc_write_cache(dc_write_cache),
    .dc_fetch(dc_fetch), .dc_update(dc_update), .dc_index(dc_index),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ack;
    int          rd;
    int          wr;
    int          fe;
    int          up;
    logic [31:0] wb;
    logic [31:0] fill;
    int          hits;
    int          misses;
  } res_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    int          kw;
    int          kf;
    res_t        exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Line-level model of the cache contents and statistics.
  bit          m_valid [64];
  bit          m_dirty [64];
  logic [23:0] m_tag   [64];
  int          m_hits;
  int          m_misses;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Predicts one transaction from the line state and updates the model.
  task automatic model_predict(input bit we, input logic [31:0] addr, input int kw,
                               input int kf, output res_t e);
    int          i;
    logic [23:0] t;
    i = int'(addr[7:2]);
    t = addr[31:8];
    e = '{0, 0, 0, 0, 0, NONE, NONE, 0, 0};
    e.rd = we ? 0 : 1;
    e.wr = we ? 1 : 0;
    if (m_valid[i] && m_tag[i] == t) begin
      e.ack = 2;
      m_hits++;
    end else begin
      m_misses++;
      e.fe   = 1;
      e.fill = {t, addr[7:2], 2'b00};
      if (m_valid[i] && m_dirty[i]) begin
        e.up  = 1;
        e.wb  = {m_tag[i], addr[7:2], 2'b00};
        e.ack = 6 + kw + kf;
      end else begin
        e.ack = 4 + kf;
      end
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_dirty[i] = 1'b0;
    end
    if (we) m_dirty[i] = 1'b1;
    e.hits   = m_hits % 65536;
    e.misses = m_misses % 65536;
  endtask

  task automatic compare_res(input string tag, input res_t o, input res_t e);
    check({tag, " ack_cycle"}, o.ack, e.ack);
    check({tag, " read_strobes"}, o.rd, e.rd);
    check({tag, " write_strobes"}, o.wr, e.wr);
    check({tag, " fetch_strobes"}, o.fe, e.fe);
    check({tag, " update_strobes"}, o.up, e.up);
    check({tag, " wb_addr"}, o.wb, e.wb);
    check({tag, " fill_addr"}, o.fill, e.fill);
    check({tag, " hit_count"}, o.hits, e.hits);
    check({tag, " miss_count"}, o.misses, e.misses);
  endtask

  // Issues one request (cycle 0 = the IDLE cycle with cpu_req high), acts as memory
  // with kw/kf wait cycles before each ack, and returns what was observed up to cpu_ack.
  task automatic run_req(input bit we, input logic [31:0] addr, input int kw, input int kf,
                         input bit junk, output res_t obs);
    int          wait_n;
    int          ns;
    bit          ack_now, prev_req, prev_we, prev_ack, fill_done, got;
    logic [31:0] prev_addr;
    obs       = '{0, 0, 0, 0, 0, NONE, NONE, 0, 0};
    wait_n    = 0;
    prev_req  = 0;
    prev_we   = 0;
    prev_ack  = 0;
    prev_addr = '0;
    fill_done = 0;
    got       = 0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = addr;
    mem_ack  = 1'b0;
    #1;
    check("idle_busy", cpu_busy, 0);
    check("idle_no_ack", cpu_ack, 0);
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (junk && cpu_busy && $urandom_range(0, 2) == 0) begin
        cpu_req  = 1'b1;
        cpu_we   = 1'($urandom_range(0, 1));
        cpu_addr = $urandom;
      end
      ack_now = mem_req && (wait_n == (mem_we ? kw : kf));
      mem_ack = ack_now;
      #1;
      check("busy_in_txn", cpu_busy, 1);
      if (fill_done) check("req_drop_after_fill_ack", mem_req, 0);
      if (mem_req && prev_req && !prev_ack) begin
        check("mem_we_hold", mem_we, prev_we);
        check("mem_addr_hold", mem_addr, prev_addr);
      end
      if (mem_req && !(prev_req && !prev_ack)) begin
        if (mem_we) obs.wb = mem_addr;
        else        obs.fill = mem_addr;
      end
      ns = int'(dc_read_cache) + int'(dc_write_cache) + int'(dc_fetch) + int'(dc_update);
      check("strobe_onehot", (ns <= 1), 1);
      if (ns != 0) check("strobe_index", dc_index, addr[7:2]);
      obs.rd += int'(dc_read_cache);
      obs.wr += int'(dc_write_cache);
      obs.fe += int'(dc_fetch);
      obs.up += int'(dc_update);
      if (mem_req) wait_n = ack_now ? 0 : wait_n + 1;
      fill_done = ack_now && !mem_we;
      prev_req  = mem_req;
      prev_we   = mem_we;
      prev_addr = mem_addr;
      prev_ack  = ack_now;
      if (cpu_ack) begin
        got        = 1;
        obs.ack    = c;
        obs.hits   = int'(hit_count);
        obs.misses = int'(miss_count);
      end
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    if (!got) check("ack_timeout", 0, 1);
  endtask

  task automatic model_run(input string tag, input bit we, input logic [31:0] addr,
                           input int kw, input int kf, input bit junk);
    res_t e, o;
    model_predict(we, addr, kw, kf, e);
    run_req(we, addr, kw, kf, junk, o);
    compare_res(tag, o, e);
  endtask

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t o, e;
    bit   found;

    // Directed vectors from empty cache; expected values derived by hand.
    vecs[0] = '{1'b0, 32'h0000_0104, 0, 3, '{7, 1, 0, 1, 0, NONE, 32'h104, 0, 1}};
    vecs[1] = '{1'b0, 32'h0000_0104, 0, 0, '{2, 1, 0, 0, 0, NONE, NONE, 1, 1}};
    vecs[2] = '{1'b1, 32'h0000_0104, 0, 0, '{2, 0, 1, 0, 0, NONE, NONE, 2, 1}};
    vecs[3] = '{1'b0, 32'h0000_0204, 2, 1, '{9, 1, 0, 1, 1, 32'h104, 32'h204, 2, 2}};
    vecs[4] = '{1'b1, 32'h0000_0010, 0, 0, '{4, 0, 1, 1, 0, NONE, 32'h010, 2, 3}};
    vecs[5] = '{1'b0, 32'h0000_0010, 0, 0, '{2, 1, 0, 0, 0, NONE, NONE, 3, 3}};
    vecs[6] = '{1'b0, 32'h0000_0110, 0, 0, '{6, 1, 0, 1, 1, 32'h010, 32'h110, 3, 4}};

    rstn     = 1'b0;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    mem_ack  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", cpu_busy, 0);
    check("rst_ack", cpu_ack, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_strobes", {dc_read_cache, dc_write_cache, dc_fetch, dc_update}, 0);
    check("rst_index", dc_index, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    rstn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_req(vecs[v].we, vecs[v].addr, vecs[v].kw, vecs[v].kf, 1'b1, o);
      compare_res($sformatf("vec%0d", v), o, vecs[v].exp);
      model_predict(vecs[v].we, vecs[v].addr, vecs[v].kw, vecs[v].kf, e);
    end

    // Dirty line 1, then reset while the write-back waits for mem_ack.
    model_run("dirty_store", 1'b1, 32'h0000_0204, 0, 0, 1'b0);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0304;
    found    = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      if (mem_req && mem_we) found = 1;
    end
    check("reach_wb_mem", found, 1);
    check("wb_mem_addr", mem_addr, 32'h0000_0204);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_busy", cpu_busy, 0);
    check("midrst_hits", hit_count, 0);
    check("midrst_misses", miss_count, 0);
    check("midrst_index", dc_index, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("stray_ack_fetch", dc_fetch, 0);
    check("stray_ack_mem_req", mem_req, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_ack_busy", cpu_busy, 0);
    check("stray_ack_misses", miss_count, 0);
    model_reset();
    model_predict(1'b0, 32'h0000_0104, 0, 1, e);
    run_req(1'b0, 32'h0000_0104, 0, 1, 1'b0, o);
    compare_res("post_rst_load", o, e);
    check("post_rst_is_miss", o.misses, 1);
    check("post_rst_fill", o.fill, 32'h0000_0104);

    // Randomized traffic over a small address pool to mix hits, clean and dirty misses.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      model_run($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), a,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the 64-line direct-mapped data cache (`cache_data_block`). It holds the tag/valid/dirty store and accepts one CPU load/store at a time. It drives the data block's `read_cache`/`write_cache`/`fetch`/`update`/`index` strobes and runs write-back eviction and line fill over a req/ack memory handshake. It sits between the pipeline memory stage and the external memory port. CPU write data, fill data and eviction data travel on datapath wires outside this block.

## Interface
Parameters:
- ADDR_W, 32, byte address width; index = addr[7:2], tag = addr[ADDR_W-1:8]
- CNT_W, 16, width of hit/miss statistics counters

Ports:
- clk  in  1  clock; controller logic on posedge
- rstn  in  1  reset, synchronous, active-low
- cpu_req  in  1  request valid, sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  byte address
- cpu_busy  out  1  high whenever state != IDLE
- cpu_ack  out  1  one-cycle pulse: load data valid on data block `data_out` / store committed
- dc_read_cache, dc_write_cache, dc_fetch, dc_update  out  1 each  strobes to data block
- dc_index  out  6  line index to data block
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write-back, 0 = fill read
- mem_addr  out  ADDR_W  word-aligned memory address (bits [1:0] = 0)
- mem_ack  in  1  one-cycle completion; fill data valid on `data_fetch` in the same cycle
- hit_count, miss_count  out  CNT_W  wrapping statistics

## Operation
- Tag store: 64 entries of {valid, dirty, tag[ADDR_W-9:0]}. Combinational read, posedge write.
- States: IDLE, LOOKUP, WB_READ, WB_MEM, FILL, RESP.
- IDLE: when cpu_req=1, latch addr and we into req_addr/req_we, then go to LOOKUP.
- LOOKUP: hit = valid[idx] && tag[idx]==req tag.
  - Load hit: assert dc_read_cache, then RESP.
  - Store hit: assert dc_write_cache, set dirty[idx], then RESP.
  - Miss with dirty line: go to WB_READ.
  - Miss with clean or invalid line: go to FILL.
  - hit_count/miss_count increment only on the first LOOKUP of a request, never on the post-fill LOOKUP.
- WB_READ: assert dc_update, which latches the victim word into `data_update` at the negedge. Go to WB_MEM.
- WB_MEM: mem_req=1, mem_we=1, mem_addr={old tag, idx, 2'b00}. On mem_ack, clear dirty[idx] and go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={req tag, idx, 2'b00}. In the mem_ack cycle:
  - assert dc_fetch;
  - write tag[idx]=req tag, valid=1, dirty=0;
  - go to LOOKUP, which then hits.
  - Write-allocate: a store miss fills first, then writes.
- RESP: cpu_ack=1, return to IDLE. A new cpu_req is not sampled in RESP.
- Output decode:
  - dc_* and mem_req/mem_we are combinational decodes of state, mem_ack and the hit result.
  - At most one dc_* strobe is high in any cycle.
  - dc_index = req_addr[7:2] in all non-IDLE states, and 0 in IDLE.
- cpu_req and mem_ack are ignored in any state where they are not listed above.

## Timing
- Data block acts on negedge. Strobes asserted in a posedge-to-posedge cycle take effect at that cycle's negedge. `data_out`/`data_update` are stable at the next posedge.
- Cycle counts are measured from the cycle in which cpu_req is sampled in IDLE (cycle 0):
  - Hit, load or store: LOOKUP in cycle 1, cpu_ack in cycle 2. Next request is accepted in cycle 3.
  - Clean miss: FILL starts in cycle 2. If mem_ack arrives in cycle 2+k, LOOKUP is in 3+k and cpu_ack in 4+k.
  - Dirty miss: WB_READ in cycle 2, WB_MEM from cycle 3 until mem_ack, then FILL, LOOKUP and RESP as above.
- mem_req/mem_we/mem_addr stay constant from the first request cycle through the ack cycle. mem_req drops in the cycle after mem_ack.
- Reset (rstn=0 at a posedge), including mid-miss:
  - state goes to IDLE; all valid and dirty bits clear; counters go to 0.
  - req regs go to 0.
  - mem_req deasserts in the following cycle.
  - Any in-flight memory transaction is abandoned; a late mem_ack is ignored.
- Outputs during reset: all outputs are 0. cpu_busy is 0 from the cycle after reset.

## Test plan
- After reset, load 0x0000_0104: miss_count=1, FILL with mem_addr=0x104, mem_ack after 3 cycles, then dc_fetch pulses with dc_index=1. cpu_ack arrives 7 cycles after the request. Repeat the load: hit, ack at cycle 2, hit_count=1.
- Store to 0x0000_0104 after the fill: dc_write_cache in LOOKUP, dirty[1]=1, no mem_req.
- Load 0x0000_0204 (same index, new tag) with line 1 dirty:
  - dc_update in WB_READ;
  - WB_MEM with mem_we=1, mem_addr=0x104;
  - then FILL with mem_addr=0x204;
  - miss_count increments by exactly 1.
- Store miss to an invalid line 0x0000_0010: fill from 0x010, then dc_write_cache on the second LOOKUP, dirty[4]=1.
- Assert rstn=0 during WB_MEM while mem_ack is withheld:
  - mem_req falls the next cycle and the state is IDLE;
  - a later stray mem_ack has no effect;
  - a subsequent load of 0x104 misses.
- Every cycle, check that at most one dc_* strobe is high, and that cpu_req pulses while busy are neither latched nor acknowledged.
